// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the IF-stage control logic and the PC sequencer.
// Signal suffixes are written from the sequencer's point of view (_i into it, _o out of it).
interface pc_sequencer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic             stall_i;
    logic             branch_i;
    logic [WIDTH-1:0] branch_target_i;
    logic             jump_i;
    logic [WIDTH-1:0] jump_target_i;
    logic             call_i;
    logic             return_i;
    logic             exception_i;
    logic [WIDTH-1:0] pc_result_o;
    logic [WIDTH-1:0] pc_add_result_o;
    logic [CW-1:0]    ras_count_o;
    logic             ras_underflow_o;

    modport master (
        output stall_i, branch_i, branch_target_i, jump_i, jump_target_i,
               call_i, return_i, exception_i,
        input  pc_result_o, pc_add_result_o, ras_count_o, ras_underflow_o
    );

    modport slave (
        input  stall_i, branch_i, branch_target_i, jump_i, jump_target_i,
               call_i, return_i, exception_i,
        output pc_result_o, pc_add_result_o, ras_count_o, ras_underflow_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, computes the wrapping sequential
// successor, arbitrates exception/return/branch/jump/stall redirects and keeps
// a circular return-address stack so call/return pairs resolve locally.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    pc_sequencer_if.slave bus
);
    localparam int unsigned      CW       = $clog2(RAS_DEPTH + 1);
    localparam int unsigned      PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [CW-1:0]    COUNT_0  = CW'(0);
    localparam logic [CW-1:0]    COUNT_1  = CW'(1);
    localparam logic [CW-1:0]    COUNT_MX = CW'(RAS_DEPTH);
    localparam logic [PW-1:0]    PTR_0    = PW'(0);
    localparam logic [PW-1:0]    PTR_1    = PW'(1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_add_s;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             unf_q;
    logic             unf_d;
    logic             wr_en_s;
    logic [PW-1:0]    wr_idx_s;
    logic             ras_empty_s;
    logic [WIDTH-1:0] ras_top_s;

    // Sequential successor; the carry out of the top bit is intentionally dropped.
    assign pc_add_s    = pc_q + STEP_W;
    assign ras_empty_s = (count_q == COUNT_0);
    // The pointer always addresses the most recently pushed entry.
    assign ras_top_s   = ras_q[ptr_q];

    assign bus.pc_result_o     = pc_q;
    assign bus.pc_add_result_o = pc_add_s;
    assign bus.ras_count_o     = count_q;
    assign bus.ras_underflow_o = unf_q;

    // Next-PC arbitration: exception, return, branch, call/jump, stall, sequential.
    always_comb begin
        pc_d = pc_add_s;
        if (bus.exception_i) begin
            pc_d = EXC_VECTOR;
        end else if (bus.return_i) begin
            // An empty stack falls back to the register-file target.
            pc_d = ras_empty_s ? bus.jump_target_i : ras_top_s;
        end else if (bus.branch_i) begin
            pc_d = bus.branch_target_i;
        end else if (bus.call_i || bus.jump_i) begin
            pc_d = bus.jump_target_i;
        end else if (bus.stall_i) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_add_s;
        end
    end

    // Return-address stack control: push, pop, top replacement, flush and underflow flag.
    always_comb begin
        ptr_d    = ptr_q;
        count_d  = count_q;
        wr_en_s  = 1'b0;
        wr_idx_s = ptr_q;
        unf_d    = 1'b0;
        if (bus.exception_i) begin
            // Trap flushes the stack and cancels any simultaneous push or pop.
            ptr_d   = PTR_0;
            count_d = COUNT_0;
        end else if (bus.return_i && bus.call_i) begin
            if (ras_empty_s) begin
                // Nothing to pop, so the link becomes a plain push.
                ptr_d    = ptr_q + PTR_1;
                wr_idx_s = ptr_q + PTR_1;
                wr_en_s  = 1'b1;
                count_d  = COUNT_1;
                unf_d    = 1'b1;
            end else begin
                // Pop and push cancel: overwrite the top in place.
                wr_idx_s = ptr_q;
                wr_en_s  = 1'b1;
            end
        end else if (bus.return_i) begin
            if (ras_empty_s) begin
                unf_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - PTR_1;
                count_d = count_q - COUNT_1;
            end
        end else if (bus.call_i && !bus.branch_i) begin
            // A full stack silently overwrites its oldest entry.
            ptr_d    = ptr_q + PTR_1;
            wr_idx_s = ptr_q + PTR_1;
            wr_en_s  = 1'b1;
            count_d  = (count_q == COUNT_MX) ? count_q : count_q + COUNT_1;
        end else begin
            ptr_d   = ptr_q;
            count_d = count_q;
        end
    end

    // PC, stack pointer, count and underflow flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= RESET_VECTOR;
            ptr_q   <= PTR_0;
            count_q <= COUNT_0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; cleared on reset so no X ever reaches the PC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            ras_q[wr_idx_s] <= pc_add_s;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with constant
// expectations plus a randomized run against a queue-based reference model.
module tb_pc_sequencer;
    localparam int unsigned W   = 32;
    localparam int unsigned D   = 4;
    localparam logic [31:0] EXC = 32'h8000_0180;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pc_sequencer_if #(.WIDTH(W), .RAS_DEPTH(D)) bus ();

    pc_sequencer #(
        .WIDTH(W), .STEP(4), .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR(EXC), .RAS_DEPTH(D)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: PC value, stack as a queue (back = top), underflow flag.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_unf;

    task automatic model_reset();
        m_pc = 32'h0;
        m_ras.delete();
        m_unf = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] add;
        add   = m_pc + 32'd4;
        m_unf = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (bus.exception_i) begin
            m_pc = EXC;
            m_ras.delete();
        end else if (bus.return_i) begin
            if (m_ras.size() == 0) begin
                m_pc  = bus.jump_target_i;
                m_unf = 1'b1;
                if (bus.call_i) m_ras.push_back(add);
            end else begin
                m_pc = m_ras[m_ras.size()-1];
                if (bus.call_i) m_ras[m_ras.size()-1] = add;
                else void'(m_ras.pop_back());
            end
        end else if (bus.branch_i) begin
            m_pc = bus.branch_target_i;
        end else if (bus.call_i) begin
            m_pc = bus.jump_target_i;
            m_ras.push_back(add);
            if (m_ras.size() > D) void'(m_ras.pop_front());
        end else if (bus.jump_i) begin
            m_pc = bus.jump_target_i;
        end else if (!bus.stall_i) begin
            m_pc = add;
        end
    endtask

    task automatic idle();
        bus.stall_i = 1'b0; bus.branch_i = 1'b0; bus.branch_target_i = 32'h0;
        bus.jump_i  = 1'b0; bus.jump_target_i = 32'h0; bus.call_i = 1'b0;
        bus.return_i = 1'b0; bus.exception_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic goto(input logic [31:0] t);
        idle(); bus.jump_i = 1'b1; bus.jump_target_i = t; tick(); idle();
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        idle(); model_reset();
        #2;
        checks++; if (bus.pc_result_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.pc_result_o, 32'h0); end
        checks++; if (bus.pc_add_result_o !== 32'h4) begin errors++; $display("FAIL reset_pcadd got=%h exp=%h", bus.pc_add_result_o, 32'h4); end
        checks++; if (bus.ras_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.ras_count_o); end
        checks++; if (bus.ras_underflow_o !== 1'b0) begin errors++; $display("FAIL reset_unf got=%b exp=0", bus.ras_underflow_o); end
        #6 rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp = 32'(i * 4);
            checks++; if (bus.pc_result_o !== exp) begin errors++; $display("FAIL seq_pc step=%0d got=%h exp=%h", i, bus.pc_result_o, exp); end
        end
    endtask

    task automatic test_async_reset();
        idle(); bus.call_i = 1'b1; bus.jump_target_i = 32'h500; tick(); idle();
        tick();
        checks++; if (bus.pc_result_o !== 32'h504 || bus.ras_count_o !== 3'd1) begin errors++; $display("FAIL pre_reset got=%h/%0d exp=504/1", bus.pc_result_o, bus.ras_count_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.pc_result_o !== 32'h0) begin errors++; $display("FAIL async_reset_pc got=%h exp=0", bus.pc_result_o); end
        checks++; if (bus.ras_count_o !== 3'd0) begin errors++; $display("FAIL async_reset_count got=%0d exp=0", bus.ras_count_o); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++; if (bus.pc_result_o !== 32'h4) begin errors++; $display("FAIL post_reset_pc got=%h exp=4", bus.pc_result_o); end
    endtask

    task automatic test_wrap();
        goto(32'hFFFF_FFF8);
        tick();
        checks++; if (bus.pc_result_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", bus.pc_result_o); end
        checks++; if (bus.pc_add_result_o !== 32'h0) begin errors++; $display("FAIL wrap_pcadd got=%h exp=0", bus.pc_add_result_o); end
        tick();
        checks++; if (bus.pc_result_o !== 32'h0) begin errors++; $display("FAIL wrap_pc2 got=%h exp=0", bus.pc_result_o); end
        goto(32'hFFFF_FFFF);
        checks++; if (bus.pc_add_result_o !== 32'h3) begin errors++; $display("FAIL wrap_odd got=%h exp=3", bus.pc_add_result_o); end
    endtask

    task automatic test_stall();
        goto(32'h100);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc_result_o !== 32'h100) begin errors++; $display("FAIL stall_hold cyc=%0d got=%h exp=100", i, bus.pc_result_o); end
        end
        bus.branch_i = 1'b1; bus.branch_target_i = 32'h200;
        tick(); idle();
        checks++; if (bus.pc_result_o !== 32'h200) begin errors++; $display("FAIL stall_branch got=%h exp=200", bus.pc_result_o); end
    endtask

    task automatic test_priority();
        idle(); bus.call_i = 1'b1; bus.jump_target_i = 32'h700; tick(); idle();
        bus.branch_i = 1'b1; bus.branch_target_i = 32'h300; bus.jump_i = 1'b1;
        bus.jump_target_i = 32'h400; bus.exception_i = 1'b1; bus.call_i = 1'b1;
        tick();
        checks++; if (bus.pc_result_o !== EXC) begin errors++; $display("FAIL prio_exc got=%h exp=%h", bus.pc_result_o, EXC); end
        checks++; if (bus.ras_count_o !== 3'd0) begin errors++; $display("FAIL prio_flush got=%0d exp=0", bus.ras_count_o); end
        bus.exception_i = 1'b0; bus.call_i = 1'b0;
        tick(); idle();
        checks++; if (bus.pc_result_o !== 32'h300) begin errors++; $display("FAIL prio_branch got=%h exp=300", bus.pc_result_o); end
    endtask

    task automatic test_ras_saturate();
        logic [31:0] exp_ret;
        goto(32'h10);
        for (int i = 1; i <= 5; i++) begin
            bus.call_i = 1'b1;
            bus.jump_target_i = (i == 5) ? 32'h1000 : 32'((i + 1) * 16);
            tick(); idle();
            checks++; if (bus.ras_count_o !== 3'((i > 4) ? 4 : i)) begin errors++; $display("FAIL ras_fill i=%0d got=%0d", i, bus.ras_count_o); end
        end
        for (int i = 0; i < 4; i++) begin
            bus.return_i = 1'b1; bus.jump_target_i = 32'h900;
            tick(); idle();
            exp_ret = 32'h54 - 32'(i * 16);
            checks++; if (bus.pc_result_o !== exp_ret) begin errors++; $display("FAIL ras_pop i=%0d got=%h exp=%h", i, bus.pc_result_o, exp_ret); end
        end
        bus.return_i = 1'b1; bus.jump_target_i = 32'h900;
        tick(); idle();
        checks++; if (bus.pc_result_o !== 32'h900) begin errors++; $display("FAIL ras_empty_ret got=%h exp=900", bus.pc_result_o); end
        checks++; if (bus.ras_underflow_o !== 1'b1) begin errors++; $display("FAIL ras_unf_set got=%b exp=1", bus.ras_underflow_o); end
        checks++; if (bus.ras_count_o !== 3'd0) begin errors++; $display("FAIL ras_unf_count got=%0d exp=0", bus.ras_count_o); end
        tick();
        checks++; if (bus.ras_underflow_o !== 1'b0) begin errors++; $display("FAIL ras_unf_clear got=%b exp=0", bus.ras_underflow_o); end
    endtask

    task automatic test_call_return_swap();
        goto(32'h10);
        bus.call_i = 1'b1; bus.jump_target_i = 32'h80; tick(); idle();
        bus.call_i = 1'b1; bus.return_i = 1'b1; bus.jump_target_i = 32'h2000;
        tick(); idle();
        checks++; if (bus.pc_result_o !== 32'h14) begin errors++; $display("FAIL swap_pc got=%h exp=14", bus.pc_result_o); end
        checks++; if (bus.ras_count_o !== 3'd1) begin errors++; $display("FAIL swap_count got=%0d exp=1", bus.ras_count_o); end
        bus.return_i = 1'b1; tick(); idle();
        checks++; if (bus.pc_result_o !== 32'h84) begin errors++; $display("FAIL swap_ret got=%h exp=84", bus.pc_result_o); end
        bus.call_i = 1'b1; bus.return_i = 1'b1; bus.jump_target_i = 32'h3000;
        tick(); idle();
        checks++; if (bus.pc_result_o !== 32'h3000 || bus.ras_count_o !== 3'd1 || bus.ras_underflow_o !== 1'b1) begin
            errors++; $display("FAIL swap_empty got=%h/%0d/%b exp=3000/1/1", bus.pc_result_o, bus.ras_count_o, bus.ras_underflow_o); end
        bus.return_i = 1'b1; tick(); idle();
        checks++; if (bus.pc_result_o !== 32'h88) begin errors++; $display("FAIL swap_empty_ret got=%h exp=88", bus.pc_result_o); end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int n = 0; n < 1500; n++) begin
            idle();
            bus.exception_i = ($urandom_range(0, 31) == 0);
            bus.return_i    = ($urandom_range(0, 5) == 0);
            bus.call_i      = ($urandom_range(0, 4) == 0);
            bus.branch_i    = ($urandom_range(0, 5) == 0);
            bus.jump_i      = ($urandom_range(0, 7) == 0);
            bus.stall_i     = ($urandom_range(0, 3) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            bus.jump_target_i   = tgt;
            bus.branch_target_i = $urandom;
            tick();
            checks++;
            if (bus.pc_result_o !== m_pc || bus.pc_add_result_o !== m_pc + 32'd4 ||
                bus.ras_count_o !== 3'(m_ras.size()) || bus.ras_underflow_o !== m_unf) begin
                errors++;
                $display("FAIL random n=%0d got pc=%h add=%h cnt=%0d unf=%b exp pc=%h add=%h cnt=%0d unf=%b",
                         n, bus.pc_result_o, bus.pc_add_result_o, bus.ras_count_o, bus.ras_underflow_o,
                         m_pc, m_pc + 32'd4, m_ras.size(), m_unf);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_wrap();
        test_stall();
        test_priority();
        test_ras_saturate();
        test_call_return_swap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the pipelined MIPS datapath, replacing the fixed PC register plus +4 adder at the head of the IF stage. Holds the PC and computes the sequential successor at a configurable step with wrap-around. Selects among exception, return, branch, jump/call and stall redirects. Keeps a small circular return-address stack (RAS) so `jal`/`jr $ra` pairs resolve without a register-file read.

## Interface
- WIDTH, 32: PC width in bits.
- STEP, 4: sequential increment, in bytes.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- EXC_VECTOR, 32'h8000_0180: PC loaded on exception.
- RAS_DEPTH, 4: return-address stack entries (≥2, power of two).

- Clk  in  1  sole clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC (hazard unit).
- Branch  in  1  taken branch resolved this cycle.
- BranchTarget  in  WIDTH  branch destination.
- Jump  in  1  unconditional jump.
- JumpTarget  in  WIDTH  destination for Jump/Call; fallback for Return.
- Call  in  1  jump-and-link: jump to JumpTarget, push link.
- Return  in  1  return: pop RAS, jump to popped address.
- Exception  in  1  trap to EXC_VECTOR.
- PCResult  out  WIDTH  current PC (registered).
- PCAddResult  out  WIDTH  PCResult + STEP, mod 2^WIDTH (combinational).
- RasCount  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- RasUnderflow  out  1  registered one-cycle pulse: Return with empty RAS.

## Operation
- Next-PC priority, highest first:
  1. Exception → EXC_VECTOR.
  2. Return → RAS top if RasCount>0, else JumpTarget.
  3. Branch → BranchTarget.
  4. Call or Jump → JumpTarget.
  5. Stall → hold.
  6. Otherwise → PCAddResult.
- Redirects (1–4) override Stall. Stall only blocks sequential advance.
- Sum is WIDTH bits, carry discarded: FFFF_FFFC + 4 → 0000_0000; FFFF_FFFF + 4 → 0000_0003. No alignment check.
- RAS is a circular buffer with top pointer and saturating count. Updates only when the winning redirect is the Call or Return itself:
  - Call: push PCAddResult; count increments, saturating at RAS_DEPTH. When full, the oldest entry is overwritten.
  - Return with count>0: pop; count decrements.
  - Return with count=0: no pointer change; RasUnderflow=1 next cycle.
  - Call and Return together: Return selects the PC (old top). Top entry is replaced by PCAddResult; count unchanged. If count=0, this is a push with RasUnderflow=1.
  - Exception: flushes RAS (count←0, pointer←0) and suppresses any simultaneous push or pop.
  - Branch winning over Call or Jump: no RAS change.

## Timing
- Reset low (async, any time): PCResult=RESET_VECTOR, RasCount=0, RasUnderflow=0, pointer=0. Entry contents are don't-care.
- Reset asserted mid-operation discards everything in flight. First rising edge after release performs a normal update from RESET_VECTOR.
- Redirect inputs are sampled at edge N. The new PC is visible after edge N, i.e. one-cycle latency. PCAddResult follows PCResult combinationally.
- RasCount updates on the same edge as the PC. RasUnderflow is high for exactly the cycle after the offending edge.
- Stall held for k cycles freezes PCResult for k cycles. No state change other than a redirect.

## Test plan
- Reset release, no controls, 4 edges → PCResult 0, 4, 8, C, 10. Reset low mid-sequence → PCResult 0 immediately, without waiting for a clock edge.
- PC=FFFF_FFF8, run → FFFF_FFFC, 0000_0000. PCAddResult at FFFF_FFFC reads 0000_0000.
- PC=100, Stall=1 for 3 cycles → PC stays 100. Stall=1 with Branch=1, BranchTarget=200 → PC 200 after one edge.
- Branch=1 (300), Jump=1 (400), Exception=1 together → 8000_0180, RasCount 0. Without Exception → 300.
- Call at PCs 10, 20, 30, 40, 50 (targets 1000+) → RasCount saturates at 4. Then 4 Returns → PCs 54, 44, 34, 24. A 5th Return with JumpTarget=900 → PC 900, RasUnderflow pulse 1 cycle, RasCount 0.
- Call at PC 10 pushes 14. Then Call+Return together at PC 80, JumpTarget 2000 → PC 14, top entry becomes 84, RasCount stays 1. Next Return → PC 84.
